// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell reused LSB first,
// with a start/busy/done handshake and held S/Cout/ovfl results.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovfl
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q,  a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,  b_sh_d;
    logic [WIDTH-1:0]   r_sh_q,  r_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   s_q,     s_d;
    logic               cout_q,  cout_d;
    logic               ovfl_q,  ovfl_d;
    logic               done_q,  done_d;

    logic               fa_sum;
    logic               fa_carry;
    logic               last_bit;

    // Single full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        cout_d   = cout_q;
        ovfl_d   = ovfl_q;
        done_d   = 1'b0;
        {fa_carry, fa_sum} = full_add(a_sh_q[0], b_sh_q[0], carry_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B here, seed the carry with sub.
                    a_sh_d  = A;
                    b_sh_d  = B ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = {fa_sum, r_sh_q[WIDTH-1:1]};
                carry_d = fa_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // carry_q is the carry into the MSB on the final bit.
                    s_d     = {fa_sum, r_sh_q[WIDTH-1:1]};
                    cout_d  = fa_carry;
                    ovfl_d  = carry_q ^ fa_carry;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovfl_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovfl_q  <= ovfl_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
    assign ovfl = ovfl_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=16): directed table, handshake
// corner cases and randomized operations against an arithmetic reference model.
module tb_serial_add_sub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
    logic         ovfl;

    int total = 0;
    int bad   = 0;
    int stab_err = 0;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .ovfl  (ovfl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] exp_s;
        logic         exp_c;
        logic         exp_o;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] rs, output logic rc, output logic ro);
        int ua, ub, ur, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            ur = ua - ub;
            sr = sa - sb;
            rc = (ua >= ub);
        end else begin
            ur = ua + ub;
            sr = sa + sb;
            rc = (ur >= 65536);
        end
        rs = ur[W-1:0];
        ro = (sr > 32767) || (sr < -32768);
    endtask

    // Waits for done; returns the number of edges since the accept edge.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 40);
    endtask

    // Issues one operation from IDLE and scrambles the inputs after the accept edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int lat);
        start = 1'b1;
        A     = a;
        B     = b;
        sub   = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        sub   = 1'($urandom);
        wait_done(lat);
    endtask

    // S, Cout and ovfl may only move on a completion edge or a reset edge.
    logic [W+1:0] out_prev = '0;
    always @(posedge clk) begin
        logic rst_smp;
        rst_smp = rst_n;
        #1;
        if (rst_smp === 1'b1 && done !== 1'b1 && {S, Cout, ovfl} !== out_prev)
            stab_err++;
        out_prev = {S, Cout, ovfl};
    end

    initial begin
        int lat;
        int ndone;
        int first_lat;
        logic [W-1:0] first_s;
        logic [W-1:0] es;
        logic ec, eo;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};

        // Reset held for two edges with start high must not accept.
        rst_n = 1'b0;
        start = 1'b1;
        sub   = 1'b0;
        A     = 16'hAAAA;
        B     = 16'h5555;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_S",    64'(S),    64'(0));
        chk("reset_Cout", 64'(Cout), 64'(0));
        chk("reset_ovfl", 64'(ovfl), 64'(0));
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", 64'(busy), 64'(0));

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(16));
            chk($sformatf("vec%0d_result", i), 64'({S, Cout, ovfl}),
                64'({vecs[i].exp_s, vecs[i].exp_c, vecs[i].exp_o}));
            chk($sformatf("vec%0d_idle", i), 64'(busy), 64'(0));
        end

        // start pulsed in RUN cycle 5 is ignored.
        start = 1'b1;
        A     = 16'h1111;
        B     = 16'h2222;
        sub   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'(1));
        ndone     = 0;
        first_lat = 0;
        first_s   = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first_lat = c;
                    first_s   = S;
                end
            end
            if (c == 4) begin
                start = 1'b1;
                A     = 16'hFFFF;
                B     = 16'h0F0F;
                sub   = 1'b1;
            end
            if (c == 5) start = 1'b0;
        end
        chk("ignored_start_ndone", 64'(ndone), 64'(1));
        chk("ignored_start_lat", 64'(first_lat), 64'(16));
        chk("ignored_start_S", 64'(first_s), 64'(16'h3333));

        // start asserted in the done cycle is accepted.
        run_op(16'h00FF, 16'h0F0F, 1'b0, lat);
        chk("b2b_first_S", 64'({S, Cout, ovfl}), 64'({16'h100E, 1'b0, 1'b0}));
        start = 1'b1;
        A     = 16'h9000;
        B     = 16'h1000;
        sub   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_accept_busy", 64'(busy), 64'(1));
        wait_done(lat);
        chk("b2b_second_lat", 64'(lat), 64'(16));
        chk("b2b_second_S", 64'({S, Cout, ovfl}), 64'({16'h8000, 1'b1, 1'b0}));

        // Reset in RUN cycle 7 aborts the operation.
        start = 1'b1;
        A     = 16'h0101;
        B     = 16'h0202;
        sub   = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_S", 64'({S, Cout, ovfl}), 64'(0));
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'(0));
        run_op(16'hC000, 16'h4000, 1'b0, lat);
        chk("after_abort_lat", 64'(lat), 64'(16));
        chk("after_abort_S", 64'({S, Cout, ovfl}), 64'({16'h0000, 1'b1, 1'b0}));

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            logic rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            if (i % 10 == 0) ra = {1'b1, {(W-1){1'b0}}} ^ W'($urandom_range(0, 3));
            if (i % 10 == 1) rb = {(W){1'b1}} ^ W'($urandom_range(0, 3));
            model(ra, rb, rs, es, ec, eo);
            run_op(ra, rb, rs, lat);
            chk($sformatf("rand%0d_lat", i), 64'(lat), 64'(16));
            chk($sformatf("rand%0d_%h_%h_%b", i, ra, rb, rs), 64'({S, Cout, ovfl}),
                64'({es, ec, eo}));
        end

        @(posedge clk);
        #2;
        chk("outputs_stable_between_dones", 64'(stab_err), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
